// File: rtl/knn_vote.sv
// k-nearest-neighbour majority vote over a pre-sorted distance/label vector.
// Define KNN_TIE_NEAREST_EN to break equal-vote ties in favour of the class seen at the nearest rank.
module knn_vote #(
    parameter int L      = 64,
    parameter int W      = 16,
    parameter int TYPE_W = 3,
    parameter int K      = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W*L-1:0]             in,
    input  logic [TYPE_W*L-1:0]        in_type,
    output logic [TYPE_W-1:0]          out_class,
    output logic [$clog2(K+1)-1:0]     out_votes,
    output logic                       out_valid
);

    localparam int NCLS = 1 << TYPE_W;
    localparam int VW   = $clog2(K + 1);
    localparam int RW   = (K > 1) ? $clog2(K) : 1;
    localparam int LW   = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SCAN,
        DONE
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [TYPE_W*L-1:0]    type_reg;
    logic [W*L-1:0]         dist_reg;
    logic [LW-1:0]          rank_reg;
    logic [TYPE_W-1:0]      scan_reg;
    logic [TYPE_W-1:0]      best_cls_reg;
    logic [VW-1:0]          best_cnt_reg;
    logic [TYPE_W-1:0]      out_class_reg;
    logic [VW-1:0]          out_votes_reg;

    logic [TYPE_W-1:0]      type_arr [L];
    logic [VW-1:0]          cnt_arr  [NCLS];
    logic [TYPE_W-1:0]      cur_type;
    logic                   accept;
    logic                   rank_last;
    logic                   scan_last;
    logic [VW-1:0]          scan_cnt;
    logic                   take;
    logic [TYPE_W-1:0]      new_cls;
    logic [VW-1:0]          new_cnt;

`ifdef KNN_TIE_NEAREST_EN
    logic [RW-1:0]          rank_arr [NCLS];
    logic [NCLS-1:0]        rank_vld_vec;
    logic [RW-1:0]          best_rank_reg;
`endif

    // Distances are held with the vector but never consulted by the vote.
    logic                   unused_dist;
    assign unused_dist = ^dist_reg;

    assign accept    = in_valid && (state_reg == IDLE);
    assign rank_last = (rank_reg == LW'(K - 1));
    assign scan_last = &scan_reg;
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_class = out_class_reg;
    assign out_votes = out_votes_reg;

    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_unpack
            assign type_arr[gi] = type_reg[gi*TYPE_W +: TYPE_W];
        end
    endgenerate

    assign cur_type = type_arr[rank_reg];

    // One vote counter per class; only ranks 0..K-1 ever reach COUNT.
    generate
        for (gi = 0; gi < NCLS; gi++) begin : g_cls
            logic [VW-1:0] cnt_reg;
            logic          hit;

            assign hit         = (state_reg == COUNT) && (cur_type == TYPE_W'(gi));
            assign cnt_arr[gi] = cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (accept) begin
                    cnt_reg <= '0;
                end else if (hit) begin
                    cnt_reg <= cnt_reg + VW'(1);
                end
            end

`ifdef KNN_TIE_NEAREST_EN
            logic [RW-1:0] first_rank_reg;
            logic          first_vld_reg;

            assign rank_arr[gi]     = first_rank_reg;
            assign rank_vld_vec[gi] = first_vld_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    first_rank_reg <= '0;
                    first_vld_reg  <= 1'b0;
                end else if (accept) begin
                    first_rank_reg <= '0;
                    first_vld_reg  <= 1'b0;
                end else if (hit && !first_vld_reg) begin
                    first_rank_reg <= rank_reg[RW-1:0];
                    first_vld_reg  <= 1'b1;
                end
            end
`endif
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = COUNT;
            COUNT:   if (rank_last) state_next = SCAN;
            SCAN:    if (scan_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Strictly-greater replacement makes the lowest class index win ties by default.
    always_comb begin
        scan_cnt = cnt_arr[scan_reg];
        take     = (scan_cnt > best_cnt_reg);
`ifdef KNN_TIE_NEAREST_EN
        if ((scan_cnt == best_cnt_reg) && (scan_cnt != '0) &&
            rank_vld_vec[scan_reg] && (rank_arr[scan_reg] < best_rank_reg)) begin
            take = 1'b1;
        end
`endif
        new_cls = take ? scan_reg : best_cls_reg;
        new_cnt = take ? scan_cnt : best_cnt_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_reg      <= '0;
            dist_reg      <= '0;
            rank_reg      <= '0;
            scan_reg      <= '0;
            best_cls_reg  <= '0;
            best_cnt_reg  <= '0;
            out_class_reg <= '0;
            out_votes_reg <= '0;
`ifdef KNN_TIE_NEAREST_EN
            best_rank_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        type_reg     <= in_type;
                        dist_reg     <= in;
                        rank_reg     <= '0;
                        scan_reg     <= '0;
                        best_cls_reg <= '0;
                        best_cnt_reg <= '0;
`ifdef KNN_TIE_NEAREST_EN
                        best_rank_reg <= '0;
`endif
                    end
                end
                COUNT: begin
                    if (!rank_last) begin
                        rank_reg <= rank_reg + LW'(1);
                    end
                end
                SCAN: begin
                    scan_reg     <= scan_reg + TYPE_W'(1);
                    best_cls_reg <= new_cls;
                    best_cnt_reg <= new_cnt;
`ifdef KNN_TIE_NEAREST_EN
                    if (take) begin
                        best_rank_reg <= rank_arr[scan_reg];
                    end
`endif
                    // Results only move here, so they stay stable between DONE states.
                    if (scan_last) begin
                        out_class_reg <= new_cls;
                        out_votes_reg <= new_cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: a K=5 and a K=1 instance share stimulus and are checked
// against a counting reference model.
module tb_knn_vote;

    localparam int L      = 64;
    localparam int W      = 16;
    localparam int TYPE_W = 3;
    localparam int NCLS   = 8;

    typedef struct {
        int cls;
        int votes;
        int acc;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic [W*L-1:0]          in_d;
    logic [TYPE_W*L-1:0]     in_type_d;
    logic                    in_ready0, in_ready1;
    logic [TYPE_W-1:0]       out_class0, out_class1;
    logic [2:0]              out_votes0;
    logic [0:0]              out_votes1;
    logic                    out_valid0, out_valid1;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_sent = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    knn_vote #(.L(L), .W(W), .TYPE_W(TYPE_W), .K(5)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in(in_d), .in_type(in_type_d), .out_class(out_class0),
        .out_votes(out_votes0), .out_valid(out_valid0)
    );

    knn_vote #(.L(L), .W(W), .TYPE_W(TYPE_W), .K(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in(in_d), .in_type(in_type_d), .out_class(out_class1),
        .out_votes(out_votes1), .out_valid(out_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Majority among the first k labels; ties resolved by lowest class or by earliest rank.
    function automatic void ref_vote(input logic [TYPE_W*L-1:0] t, input int k,
                                     output int cls, output int votes);
        int tally[NCLS];
        int best;
        int lab;
        foreach (tally[c]) tally[c] = 0;
        for (int r = 0; r < k; r++) begin
            lab = int'(t[r*TYPE_W +: TYPE_W]);
            tally[lab]++;
        end
        best = 0;
        foreach (tally[c]) if (tally[c] > best) best = tally[c];
        votes = best;
        cls   = -1;
`ifdef KNN_TIE_NEAREST_EN
        for (int r = 0; r < k; r++) begin
            lab = int'(t[r*TYPE_W +: TYPE_W]);
            if (cls < 0 && tally[lab] == best) cls = lab;
        end
`else
        for (int c = 0; c < NCLS; c++) begin
            if (cls < 0 && tally[c] == best) cls = c;
        end
`endif
    endfunction

    function automatic logic [TYPE_W*L-1:0] mk_types(input int a0, input int a1, input int a2,
                                                     input int a3, input int a4, input int rest);
        logic [TYPE_W*L-1:0] v;
        int head[5];
        head = '{a0, a1, a2, a3, a4};
        for (int i = 0; i < L; i++) begin
            if (i < 5) v[i*TYPE_W +: TYPE_W] = TYPE_W'(head[i]);
            else if (rest >= 0) v[i*TYPE_W +: TYPE_W] = TYPE_W'(rest);
            else v[i*TYPE_W +: TYPE_W] = TYPE_W'($urandom_range(0, NCLS - 1));
        end
        return v;
    endfunction

    function automatic logic [W*L-1:0] mk_dist();
        logic [W*L-1:0] v;
        int acc;
        acc = 0;
        for (int i = 0; i < L; i++) begin
            acc += $urandom_range(0, 50);
            v[i*W +: W] = W'(acc);
        end
        return v;
    endfunction

    task automatic send(input logic [TYPE_W*L-1:0] t);
        int n, c0, v0, c1, v1, acc;
        n = 0;
        @(negedge clk);
        while (!(in_ready0 && in_ready1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready0=%0d in_ready1=%0d required=1", in_ready0, in_ready1);
            return;
        end
        in_type_d = t;
        in_d      = mk_dist();
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        ref_vote(t, 5, c0, v0);
        ref_vote(t, 1, c1, v1);
        q0.push_back('{c0, v0, acc});
        q1.push_back('{c1, v1, acc});
        in_valid = 1'b0;
        n_sent++;
        $display("send %0d: k5 expect class=%0d votes=%0d, k1 expect class=%0d votes=%0d",
                 n_sent, c0, v0, c1, v1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL k5_unexpected_valid class=%0d votes=%0d required=no_result",
                         out_class0, out_votes0);
            end else begin
                e0 = q0.pop_front();
                chk("k5_class", int'(out_class0), e0.cls);
                chk("k5_votes", int'(out_votes0), e0.votes);
                chk("k5_latency", cyc - e0.acc, 5 + NCLS);
                chk("k5_ready_low_in_done", int'(in_ready0), 0);
                $display("recv k5: class=%0d votes=%0d latency=%0d", out_class0, out_votes0, cyc - e0.acc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL k1_unexpected_valid class=%0d votes=%0d required=no_result",
                         out_class1, out_votes1);
            end else begin
                e1 = q1.pop_front();
                chk("k1_class", int'(out_class1), e1.cls);
                chk("k1_votes", int'(out_votes1), e1.votes);
                chk("k1_latency", cyc - e1.acc, 1 + NCLS);
                $display("recv k1: class=%0d votes=%0d latency=%0d", out_class1, out_votes1, cyc - e1.acc);
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_d      = '0;
        in_type_d = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", int'(in_ready0), 1);
        chk("reset_out_valid", int'(out_valid0), 0);
        chk("reset_out_class", int'(out_class0), 0);
        chk("reset_out_votes", int'(out_votes0), 0);
        rst = 1'b0;

        send(mk_types(2, 2, 1, 2, 3, -1));
        send(mk_types(4, 1, 1, 4, 0, -1));
        send(mk_types(5, 3, 3, 3, 3, -1));

        // A second in_valid while busy must be dropped without disturbing the vote.
        send(mk_types(7, 7, 7, 7, 7, 6));
        repeat (2) @(posedge clk);
        #1;
        in_type_d = mk_types(4, 1, 1, 4, 0, -1);
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(mk_types(4, 1, 1, 4, 0, 2));

        // Reset pulse while both instances are scanning classes.
        send(mk_types(3, 3, 3, 0, 1, -1));
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready0), 1);
        chk("midrst_out_valid", int'(out_valid0), 0);
        chk("midrst_out_class", int'(out_class0), 0);
        chk("midrst_out_votes", int'(out_votes0), 0);
        chk("midrst_k1_in_ready", int'(in_ready1), 1);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        send(mk_types(2, 2, 1, 2, 3, -1));

        for (int i = 0; i < 30; i++) begin
            int hi;
            hi = (i % 2 == 0) ? 2 : NCLS - 1;
            send(mk_types($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi),
                          $urandom_range(0, hi), $urandom_range(0, hi), -1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_k5_pending", q0.size(), 0);
        chk("drain_k1_pending", q1.size(), 0);
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_vote.md
KNN_VOTE -- requirements
Module: knn_vote

Interface
REQ-001 SHALL have parameter L, default 64: number of entries in the sorted input vector.
REQ-002 SHALL have parameter W, default 16: distance width per entry.
REQ-003 SHALL have parameter TYPE_W, default 3: class-label width; NCLS = 2^TYPE_W classes.
REQ-004 SHALL have parameter K, default 5: neighbours voting; legal range 1..L.
REQ-005 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port: in_valid  input  1  sorted vector present.
REQ-008 SHALL have port: in_ready  output  1  block idle, can accept.
REQ-009 SHALL have port: in  input  W*L  distances, ascending; entry i at bits [W*i +: W], entry 0 nearest.
REQ-010 SHALL have port: in_type  input  TYPE_W*L  labels; entry i at [TYPE_W*i +: TYPE_W].
REQ-011 SHALL have port: out_class  output  TYPE_W  winning class.
REQ-012 SHALL have port: out_votes  output  clog2(K+1)  vote count of winner.
REQ-013 SHALL have port: out_valid  output  1  one-cycle result strobe.

Function
REQ-014 SHALL implement FSM IDLE -> COUNT -> SCAN -> DONE -> IDLE.
REQ-015 SHALL drive in_ready = 1 only in IDLE, combinationally from state.
REQ-016 SHALL accept on a rising edge with in_valid=1 in IDLE: register in_type (and in), clear all NCLS counters, rank index = 0, enter COUNT.
REQ-017 SHALL ignore in_valid outside IDLE; no buffering, no effect on the running vote.
REQ-018 SHALL, in COUNT, take one entry per cycle, ranks 0..K-1: increment counter[type[rank]]; enter SCAN after rank K-1.
REQ-019 SHALL ignore entries at ranks K..L-1 entirely.
REQ-020 SHALL size counters at clog2(K+1) bits; they never exceed K, so no saturation logic.
REQ-021 SHALL, in SCAN, visit one class per cycle, 0..NCLS-1, keeping best class/count; replace only on strictly greater count, so default tie-break = lowest class index; enter DONE after class NCLS-1.
REQ-022 SHALL, in DONE, assert out_valid for exactly one cycle with out_class/out_votes valid, then return to IDLE.
REQ-023 SHALL hold out_class/out_votes stable from DONE until the next DONE.
REQ-024 SHALL assert out_valid exactly K+NCLS edges after the accepting edge: 13 cycles at defaults.
REQ-025 SHALL have in_ready high again the cycle after DONE; initiation interval K+NCLS+1 cycles.
REQ-026 SHALL treat in as captured but unused unless REQ-031 applies (distance not consulted by the vote).

Reset
REQ-027 SHALL, on rst=1, asynchronously force: state IDLE, in_ready=1, out_valid=0, out_class=0, out_votes=0, counters=0, rank=0.
REQ-028 SHALL abandon any vote in progress on reset mid-COUNT/SCAN/DONE; no out_valid for that vector.
REQ-029 SHALL not accept in_valid while rst=1; first accept is on the first edge after deassertion.

Configuration
REQ-030 SHALL gate tie-break-by-proximity logic with macro KNN_TIE_NEAREST_EN.
REQ-031 SHALL, with KNN_TIE_NEAREST_EN defined: record per class the first rank it appeared in COUNT (clog2(K) bits, valid flag); in SCAN on equal count, the class with smaller first rank wins.
REQ-032 SHALL, without KNN_TIE_NEAREST_EN: no first-rank registers; tie-break per REQ-021; latency identical both ways.

Verification
REQ-033 SHALL test defaults, in_type ranks 0..4 = 2,2,1,2,3 -> out_class=2, out_votes=3, out_valid exactly 13 cycles after accept.
REQ-034 SHALL test ranks 0..4 = 4,1,1,4,0 -> out_class=1, votes=2 without macro; out_class=4, votes=2 with KNN_TIE_NEAREST_EN.
REQ-035 SHALL test ranks 0..4 all 7, ranks 5..63 all 6 -> out_class=7, out_votes=5 (ranks >= K ignored).
REQ-036 SHALL test second in_valid 3 cycles after accept -> ignored, result matches first vector; vector re-presented after in_ready=1 -> accepted, its own result.
REQ-037 SHALL test rst pulse during SCAN -> out_valid never asserts, outputs 0, in_ready=1 immediately; next vector gives correct result at 13 cycles.
REQ-038 SHALL test K=1, ranks 0..4 = 5,3,3,3,3 -> out_class=5, out_votes=1, latency 1+NCLS = 9.
